// File: rtl/axi4_slave_wr_txn_collector.sv
// axi4_slave_wr_txn_collector
//   Passive tap on one slave-side AXI4 write port. It pairs each AW with its
//   W beats and the matching B response, and emits one completed-transaction
//   record per write. It never drives the bus. A full record FIFO drops
//   records and raises a flag; it never stalls AXI.
// Ports
//   aclk, areset                   clock, synchronous active-high reset
//   aw*/w*/b* (inputs)             handshake taps of the write channels
//   txn_valid / txn_ready          record output handshake (head of OUT FIFO)
//   txn_id/addr/len/size/burst     captured AW fields
//   txn_resp                       captured BRESP
//   txn_data_xor                   XOR over all beats of strobe-masked wdata
//   txn_wlast_err                  WLAST early or missing on the final beat
//   err_orphan_w/err_orphan_b/err_ovf  sticky error flags
module axi4_slave_wr_txn_collector #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned ID_WIDTH   = 4,
  parameter int unsigned AW_DEPTH   = 4,
  parameter int unsigned DC_DEPTH   = 4,
  parameter int unsigned OUT_DEPTH  = 2
) (
  input  logic                    aclk,
  input  logic                    areset,
  input  logic                    awvalid,
  input  logic                    awready,
  input  logic [ID_WIDTH-1:0]     awid,
  input  logic [ADDR_WIDTH-1:0]   awaddr,
  input  logic [7:0]              awlen,
  input  logic [2:0]              awsize,
  input  logic [1:0]              awburst,
  input  logic                    wvalid,
  input  logic                    wready,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic                    wlast,
  input  logic                    bvalid,
  input  logic                    bready,
  input  logic [ID_WIDTH-1:0]     bid,
  input  logic [1:0]              bresp,
  output logic                    txn_valid,
  input  logic                    txn_ready,
  output logic [ID_WIDTH-1:0]     txn_id,
  output logic [ADDR_WIDTH-1:0]   txn_addr,
  output logic [7:0]              txn_len,
  output logic [2:0]              txn_size,
  output logic [1:0]              txn_burst,
  output logic [1:0]              txn_resp,
  output logic [DATA_WIDTH-1:0]   txn_data_xor,
  output logic                    txn_wlast_err,
  output logic                    err_orphan_w,
  output logic                    err_orphan_b,
  output logic                    err_ovf
);

  localparam int unsigned SW  = DATA_WIDTH / 8;
  localparam int unsigned AWC = $clog2(AW_DEPTH + 1);
  localparam int unsigned DCC = $clog2(DC_DEPTH + 1);
  localparam int unsigned OC  = $clog2(OUT_DEPTH + 1);

  typedef struct packed {
    logic [ID_WIDTH-1:0]   id;
    logic [ADDR_WIDTH-1:0] addr;
    logic [7:0]            len;
    logic [2:0]            size;
    logic [1:0]            burst;
  } aw_t;

  typedef struct packed {
    aw_t                   aw;
    logic [DATA_WIDTH-1:0] acc;
    logic                  werr;
  } dc_t;

  typedef struct packed {
    dc_t       dc;
    logic [1:0] resp;
  } rec_t;

  // All queues are shift-compacted: slot 0 is always the oldest entry.
  aw_t  aw_q  [AW_DEPTH];
  dc_t  dc_q  [DC_DEPTH];
  rec_t out_q [OUT_DEPTH];
  logic [AWC-1:0] aw_cnt;
  logic [DCC-1:0] dc_cnt;
  logic [OC-1:0]  out_cnt;
  logic [7:0]            beat_cnt;
  logic [DATA_WIDTH-1:0] acc;

  aw_t  aw_n  [AW_DEPTH];
  dc_t  dc_n  [DC_DEPTH];
  rec_t out_n [OUT_DEPTH];
  logic [AWC-1:0] aw_cnt_n;
  logic [DCC-1:0] dc_cnt_n;
  logic [OC-1:0]  out_cnt_n;
  logic [7:0]            beat_n;
  logic [DATA_WIDTH-1:0] acc_n;
  logic ow_n, ob_n, ovf_n;

  logic aw_hs, w_hs, b_hs;
  logic [DATA_WIDTH-1:0] wmask;
  logic [DATA_WIDTH-1:0] acc_x;
  aw_t  aw_in, cur;
  logic have_head, last_beat, aw_pop, dc_push, hit, out_pop;
  dc_t  dc_ent;
  rec_t rec;
  int unsigned sel, n_aw, n_dc, n_out;

  assign aw_hs = awvalid & awready;
  assign w_hs  = wvalid & wready;
  assign b_hs  = bvalid & bready;

  always_comb begin
    wmask = '0;
    for (int unsigned i = 0; i < SW; i++) begin
      wmask[i*8 +: 8] = {8{wstrb[i]}};
    end
  end

  always_comb begin
    aw_n      = aw_q;
    dc_n      = dc_q;
    out_n     = out_q;
    aw_cnt_n  = aw_cnt;
    dc_cnt_n  = dc_cnt;
    out_cnt_n = out_cnt;
    beat_n    = beat_cnt;
    acc_n     = acc;
    ow_n      = err_orphan_w;
    ob_n      = err_orphan_b;
    ovf_n     = err_ovf;
    aw_pop    = 1'b0;
    dc_push   = 1'b0;
    dc_ent    = '0;
    hit       = 1'b0;
    sel       = 0;
    rec       = '0;

    aw_in.id    = awid;
    aw_in.addr  = awaddr;
    aw_in.len   = awlen;
    aw_in.size  = awsize;
    aw_in.burst = awburst;

    // An AW arriving on an empty queue is visible to a W beat in the same cycle.
    have_head = (aw_cnt != '0) || aw_hs;
    cur       = (aw_cnt != '0) ? aw_q[0] : aw_in;
    acc_x     = acc ^ (wdata & wmask);
    last_beat = (beat_cnt == cur.len);

    // ---------------- W path ----------------
    if (w_hs) begin
      if (!have_head) begin
        ow_n = 1'b1;
      end else if (wlast || last_beat) begin
        aw_pop      = 1'b1;
        dc_push     = 1'b1;
        dc_ent.aw   = cur;
        dc_ent.acc  = acc_x;
        dc_ent.werr = wlast ^ last_beat;  // early wlast, or final beat without wlast
        acc_n       = '0;
        beat_n      = '0;
      end else begin
        acc_n  = acc_x;
        beat_n = beat_cnt + 8'd1;
      end
    end

    // ---------------- AW queue ----------------
    n_aw = 32'(aw_cnt);
    if (aw_pop && n_aw != 0) begin
      for (int unsigned i = 0; i + 1 < AW_DEPTH; i++) aw_n[i] = aw_q[i+1];
      aw_n[AW_DEPTH-1] = '0;
      n_aw = n_aw - 1;
    end
    // When the bypassed AW also closes its burst it is consumed, not queued.
    if (aw_hs && !(aw_pop && aw_cnt == '0)) begin
      if (n_aw == AW_DEPTH) begin
        ovf_n = 1'b1;
      end else begin
        for (int unsigned i = 0; i < AW_DEPTH; i++) if (i == n_aw) aw_n[i] = aw_in;
        n_aw = n_aw + 1;
      end
    end
    aw_cnt_n = AWC'(n_aw);

    // ---------------- B path / DC queue ----------------
    // Search uses pre-cycle DC state, so a burst closing this cycle cannot match.
    n_dc = 32'(dc_cnt);
    for (int unsigned i = 0; i < DC_DEPTH; i++) begin
      if (b_hs && !hit && i < n_dc && dc_q[i].aw.id == bid) begin
        hit = 1'b1;
        sel = i;
      end
    end
    if (b_hs && !hit) ob_n = 1'b1;
    if (hit) begin
      rec.dc   = dc_q[sel];
      rec.resp = bresp;
      for (int unsigned i = 0; i + 1 < DC_DEPTH; i++) begin
        if (i >= sel) dc_n[i] = dc_q[i+1];
      end
      dc_n[DC_DEPTH-1] = '0;
      n_dc = n_dc - 1;
    end
    if (dc_push) begin
      if (n_dc == DC_DEPTH) begin
        ovf_n = 1'b1;
      end else begin
        for (int unsigned i = 0; i < DC_DEPTH; i++) if (i == n_dc) dc_n[i] = dc_ent;
        n_dc = n_dc + 1;
      end
    end
    dc_cnt_n = DCC'(n_dc);

    // ---------------- OUT FIFO ----------------
    n_out   = 32'(out_cnt);
    out_pop = (out_cnt != '0) && txn_ready;
    if (out_pop) begin
      for (int unsigned i = 0; i + 1 < OUT_DEPTH; i++) out_n[i] = out_q[i+1];
      out_n[OUT_DEPTH-1] = '0;
      n_out = n_out - 1;
    end
    if (hit) begin
      if (n_out == OUT_DEPTH) begin
        ovf_n = 1'b1;
      end else begin
        for (int unsigned i = 0; i < OUT_DEPTH; i++) if (i == n_out) out_n[i] = rec;
        n_out = n_out + 1;
      end
    end
    out_cnt_n = OC'(n_out);
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      for (int unsigned i = 0; i < AW_DEPTH; i++)  aw_q[i]  <= '0;
      for (int unsigned i = 0; i < DC_DEPTH; i++)  dc_q[i]  <= '0;
      for (int unsigned i = 0; i < OUT_DEPTH; i++) out_q[i] <= '0;
      aw_cnt       <= '0;
      dc_cnt       <= '0;
      out_cnt      <= '0;
      beat_cnt     <= '0;
      acc          <= '0;
      err_orphan_w <= 1'b0;
      err_orphan_b <= 1'b0;
      err_ovf      <= 1'b0;
    end else begin
      aw_q         <= aw_n;
      dc_q         <= dc_n;
      out_q        <= out_n;
      aw_cnt       <= aw_cnt_n;
      dc_cnt       <= dc_cnt_n;
      out_cnt      <= out_cnt_n;
      beat_cnt     <= beat_n;
      acc          <= acc_n;
      err_orphan_w <= ow_n;
      err_orphan_b <= ob_n;
      err_ovf      <= ovf_n;
    end
  end

  // Vacated FIFO slots are zeroed, so the head reads as all-zero when empty.
  assign txn_valid     = (out_cnt != '0);
  assign txn_id        = out_q[0].dc.aw.id;
  assign txn_addr      = out_q[0].dc.aw.addr;
  assign txn_len       = out_q[0].dc.aw.len;
  assign txn_size      = out_q[0].dc.aw.size;
  assign txn_burst     = out_q[0].dc.aw.burst;
  assign txn_resp      = out_q[0].resp;
  assign txn_data_xor  = out_q[0].dc.acc;
  assign txn_wlast_err = out_q[0].dc.werr;

endmodule
